// File: rtl/arb8_sel_if.sv
// arb8_sel_if: request/grant bundle between the eight requesters, the
// downstream consumer and the arb8_sel arbiter.
//
// Handshake: a requester holds its req_in bit until it sees its gnt_out bit.
// A grant (gnt_valid_out = 1) stays held, with sel_out/gnt_out frozen, until
// the consumer pulses done_in for one cycle.
interface arb8_sel_if;
    logic [7:0] req_in;
    logic       done_in;
    logic [2:0] sel_out;
    logic [7:0] gnt_out;
    logic       gnt_valid_out;
    logic       timeout_out;

    // requester/consumer side
    modport master (
        output req_in,
        output done_in,
        input  sel_out,
        input  gnt_out,
        input  gnt_valid_out,
        input  timeout_out
    );

    // arbiter side
    modport slave (
        input  req_in,
        input  done_in,
        output sel_out,
        output gnt_out,
        output gnt_valid_out,
        output timeout_out
    );
endinterface

// File: rtl/arb8_sel.sv
// arb8_sel: round-robin arbiter owning the 3-bit select of the shared 8:1 mux.
// sel_out changes only on entry to GRANT, so the mux stays stable mid-transfer.
// Optional feature macro: ARB8_TIMEOUT_EN (forced release after TIMEOUT_CYCLES
// grant cycles without done_in, flagged by a one-cycle timeout_out pulse).
module arb8_sel #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    arb8_sel_if.slave  bus,
    output logic [1:0] o_dbg_state,
    output logic [2:0] o_dbg_ptr
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("arb8_sel: TIMEOUT_CYCLES must be in 2..255");
    end

    logic [1:0]  r_state;
    logic [2:0]  r_ptr;
    logic [2:0]  r_sel;
    logic [7:0]  r_gnt;
    logic        r_gnt_valid;

    logic [15:0] w_dbl;
    logic [7:0]  w_rot;
    logic [2:0]  w_off;
    logic [2:0]  w_pick;
    logic        w_found;

    // rotate requests so bit 0 is the ptr position, then take the lowest set bit
    assign w_dbl   = {bus.req_in, bus.req_in};
    assign w_rot   = 8'(w_dbl >> r_ptr);
    assign w_found = |bus.req_in;
    assign w_pick  = r_ptr + w_off;

    // priority encoder over the rotated request vector
    always_comb begin
        w_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (w_rot[k]) w_off = 3'(k);
        end
    end

`ifdef ARB8_TIMEOUT_EN
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_cnt;
    logic       r_timeout;

    // grant-age counter and forced-release pulse
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state == S_IDLE) begin
                r_cnt <= 8'd0;
            end else if (r_state == S_GRANT && !bus.done_in) begin
                if (r_cnt == LP_TO_LAST) r_timeout <= 1'b1;
                else                     r_cnt     <= r_cnt + 8'd1;
            end
        end
    end

    assign bus.timeout_out = r_timeout;
    wire w_force_rel = (r_cnt == LP_TO_LAST);
`else
    assign bus.timeout_out = 1'b0;
    wire w_force_rel = 1'b0;
`endif

    // main FSM: IDLE picks, GRANT holds until done (or timeout), RELEASE turns around
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_ptr       <= 3'd0;
            r_sel       <= 3'd0;
            r_gnt       <= 8'h00;
            r_gnt_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_sel       <= w_pick;
                        r_gnt       <= 8'h01 << w_pick;
                        r_gnt_valid <= 1'b1;
                        r_state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (bus.done_in || w_force_rel) begin
                        r_ptr       <= r_sel + 3'd1;
                        r_gnt       <= 8'h00;
                        r_gnt_valid <= 1'b0;
                        r_state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_gnt       <= 8'h00;
                    r_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel_out       = r_sel;
    assign bus.gnt_out       = r_gnt;
    assign bus.gnt_valid_out = r_gnt_valid;
    assign o_dbg_state       = r_state;
    assign o_dbg_ptr         = r_ptr;
endmodule

// File: tb/tb_arb8_sel.sv
// tb_arb8_sel: directed bench for arb8_sel with a queue of expected grant
// indices computed by a reference round-robin search.
module tb_arb8_sel;
    logic       clk_in;
    logic       rst_in;
    logic [1:0] dbg_state;
    logic [2:0] dbg_ptr;

    arb8_sel_if bus ();

    arb8_sel #(.TIMEOUT_CYCLES(4)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .bus         (bus),
        .o_dbg_state (dbg_state),
        .o_dbg_ptr   (dbg_ptr)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int         n_total = 0;
    int         n_pass  = 0;
    logic [2:0] m_ptr   = 3'd0;
    logic [2:0] exp_q[$];

    // reference: first set bit in order ptr, ptr+1, ... mod 8
    function automatic logic [2:0] model_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        for (int k = 0; k < 8; k++) begin
            idx = 3'(p + 3'(k));
            if (r[idx]) return idx;
        end
        return 3'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // push the reference pick for the current request pattern
    task automatic expect_grant(input logic [7:0] r);
        exp_q.push_back(model_pick(r, m_ptr));
    endtask

    // wait (bounded) for a grant, then compare latency, index and one-hot vector
    task automatic wait_grant(input string tag, input int exp_lat);
        int n;
        logic [2:0] e;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.gnt_valid_out && n < 10);
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_valid"}, {31'd0, bus.gnt_valid_out}, 1);
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_sel"}, {29'd0, bus.sel_out}, {29'd0, e});
            check({tag, "_gnt"}, {24'd0, bus.gnt_out}, {24'd0, 8'h01 << e});
        end
    endtask

    // pulse done on the current grant cycle; checks the grant drops next cycle
    task automatic release_grant(input string tag);
        logic [2:0] s;
        s = bus.sel_out;
        bus.done_in = 1'b1;
        step();
        bus.done_in = 1'b0;
        m_ptr = 3'(s + 3'd1);
        check({tag, "_rel_valid"}, {31'd0, bus.gnt_valid_out}, 0);
        check({tag, "_rel_gnt"}, {24'd0, bus.gnt_out}, 0);
        check({tag, "_rel_sel"}, {29'd0, bus.sel_out}, {29'd0, s});
        check({tag, "_rel_ptr"}, {29'd0, dbg_ptr}, {29'd0, m_ptr});
        check({tag, "_rel_to"}, {31'd0, bus.timeout_out}, 0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        m_ptr = 3'd0;
    endtask

    // directed sequence
    initial begin
        rst_in      = 1'b1;
        bus.req_in  = 8'h00;
        bus.done_in = 1'b0;
        step();
        step();
        rst_in = 1'b0;

        // idle after reset: nothing granted
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_outs", {bus.gnt_out, bus.gnt_valid_out, bus.sel_out, bus.timeout_out}, 0);
            check("reset_state", {dbg_state, dbg_ptr}, 0);
        end

        // done in IDLE is ignored
        bus.done_in = 1'b1;
        step();
        bus.done_in = 1'b0;
        check("idle_done_ign", {bus.gnt_valid_out, dbg_ptr}, 0);

        // single requester 5
        bus.req_in = 8'h20;
        expect_grant(bus.req_in);
        wait_grant("single5", 1);
        bus.req_in = 8'h00;
        release_grant("single5");
        step();
        check("single5_idle", {30'd0, dbg_state}, 0);

        // full contention from ptr 0: order 0..7 with 2-cycle gaps
        do_reset();
        bus.req_in = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            expect_grant(bus.req_in);
            wait_grant($sformatf("rr%0d", k), (k == 0) ? 1 : 2);
            if (k < 7) release_grant($sformatf("rr%0d", k));
        end

        // wrap: 7 released, 0 wins over 7, select holds 7 in the gap
        bus.req_in = 8'h81;
        release_grant("wrap7");
        check("wrap_ptr0", {29'd0, dbg_ptr}, 0);
        step();
        check("wrap_gap_sel", {29'd0, bus.sel_out}, 7);
        check("wrap_gap_valid", {31'd0, bus.gnt_valid_out}, 0);
        expect_grant(bus.req_in);
        wait_grant("wrap0", 1);
        release_grant("wrap0");
        expect_grant(bus.req_in);
        wait_grant("wrap7b", 2);
        bus.req_in = 8'h00;
        release_grant("wrap7b");
        step();

        // requester 3 drops its line mid-grant: grant held
        bus.req_in = 8'h08;
        expect_grant(bus.req_in);
        wait_grant("hold3", 1);
        bus.req_in = 8'h00;
        step();
        step();
        check("hold3_sel", {29'd0, bus.sel_out}, 3);
        check("hold3_valid", {31'd0, bus.gnt_valid_out}, 1);

        // reset mid-grant
        do_reset();
        check("rstmid_outs", {bus.gnt_out, bus.gnt_valid_out, bus.sel_out}, 0);
        check("rstmid_state", {dbg_state, dbg_ptr}, 0);
        bus.req_in = 8'h09;
        expect_grant(bus.req_in);
        wait_grant("after_rst", 1);
        bus.req_in = 8'h00;
        release_grant("after_rst");
        step();

`ifdef ARB8_TIMEOUT_EN
        // forced release after 4 grant cycles
        bus.req_in = 8'h04;
        expect_grant(bus.req_in);
        wait_grant("to_a", 1);
        bus.req_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("to_a_held", {bus.gnt_valid_out, bus.timeout_out}, 2'b10);
        end
        step();
        check("to_a_rel", {bus.gnt_valid_out, bus.timeout_out}, 2'b01);
        check("to_a_ptr", {29'd0, dbg_ptr}, 3);
        step();
        check("to_a_pulse_end", {30'd0, dbg_state, bus.timeout_out}, 0);

        // done on the 4th cycle: normal release, no pulse
        bus.req_in = 8'h04;
        m_ptr = 3'd3;
        expect_grant(bus.req_in);
        wait_grant("to_b", 1);
        bus.req_in = 8'h00;
        for (int i = 0; i < 3; i++) step();
        release_grant("to_b");
        step();
        check("to_b_no_pulse", {31'd0, bus.timeout_out}, 0);
`else
        // no timeout built: grant held indefinitely without done
        bus.req_in = 8'h04;
        expect_grant(bus.req_in);
        wait_grant("nto", 1);
        bus.req_in = 8'h00;
        for (int i = 0; i < 20; i++) step();
        check("nto_held", {bus.gnt_valid_out, bus.timeout_out}, 2'b10);
        release_grant("nto");
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
